div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Multi-cycle 32-bit signed/unsigned radix-2 restoring divider for the MIPS DIV/DIVU path.
//  Sits upstream of the HI/LO write-back: EX launches it, and quotient->LO, remainder->HI.
//  Each iteration does one trial subtraction: a 33-bit add-with-carry of the partial
//  remainder and the inverted, zero-extended divisor, with carry-in 1.
// PARAMETERS
//  WIDTH   32  operand/result width; iteration count = WIDTH
//  CNT_W   6   iteration counter width (>= clog2(WIDTH)+1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous reset, active-high
//  start       in   1      launch request; accepted only when busy==0
//  signed_div  in   1      1 = DIV (two's complement), 0 = DIVU
//  dividend    in   WIDTH  sampled on the accepting edge
//  divisor     in   WIDTH  sampled on the accepting edge
//  cancel      in   1      abort (exception/flush); priority over start
//  busy        out  1      high while a division is in flight
//  done        out  1      one-cycle pulse: results valid
//  quotient    out  WIDTH  held until the next done
//  remainder   out  WIDTH  held until the next done
//  div_zero    out  1      divisor was 0; valid with done, held
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0.
//  FSM: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//   - IDLE: start=1 & cancel=0 -> latch |dividend| and |divisor| (abs only if signed_div),
//     the quotient sign (sd ^ sv), the remainder sign (sd) and div_zero; cnt=0; go to CALC.
//   - CALC: P={R[31:0],Q[31]}; T=P + ~{1'b0,D} + 1 (33-bit).
//     If T[32]==0: R=T, Q={Q[30:0],1}. Otherwise R=P, Q={Q[30:0],0}.
//     cnt++; leave after WIDTH steps.
//   - FIX: quotient = qsign ? -Q : Q; remainder = rsign ? -R : R.
//     done=1 on the next cycle; return to IDLE.
//  Latency: start sampled in cycle N -> busy=1 for N+1..N+33 -> done=1 in N+34, busy=0.
//   Back-to-back: a start in the done cycle is accepted.
//  start while busy=1: ignored. No queueing.
//  cancel=1 in any state: IDLE on the next edge. done is not pulsed; the result outputs
//   keep their previous values. cancel together with start in IDLE: start is dropped.
//  Reset mid-operation: immediate return to reset state; the partial result is discarded.
//  Divide by zero (no trap): the algorithm result is delivered unchanged.
//   DIVU x/0 -> Q=0xFFFFFFFF, rem=x. DIV applies the sign fix-up to these values.
//  Overflow: DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wraps, no flag).
//  Arithmetic: abs and negate are two's complement, WIDTH bits; |0x80000000| = 0x80000000
//   as an unsigned value. Division by 1 and by 0 take full latency unless the option below is set.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: divisor==0 on the accepting edge skips CALC and goes straight to FIX,
//   using Q=all-ones and R=|dividend|. Done in N+2; outputs are identical to the full-latency case.
//  Not defined: every division takes the N+34 latency, including divide by zero.
// TESTING
//  1. DIVU 100/7 -> done at N+34, quotient=14, remainder=2, div_zero=0; busy high exactly 33 cycles.
//  2. DIV -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
//     DIV 7/-2 -> quotient=-3, remainder=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
//     DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
//  4. DIVU 0x1234/0 -> quotient=0xFFFFFFFF, remainder=0x1234, div_zero=1.
//     done at N+34 without the macro, N+2 with DIV_ZERO_FAST_EN.
//  5. Start 100/7 and raise cancel at cycle N+10 -> busy=0 at N+11, no done pulse,
//     outputs keep the prior result. A fresh start at N+12 completes normally.
//  6. Second start pulsed at N+5 (ignored) and rst at N+20 -> all outputs 0 at N+21, no done.
//     Then start in the done cycle of a run -> accepted, next done 34 cycles later.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider (DIV/DIVU), quotient->LO, remainder->HI.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips the iteration phase.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
    logic qs_q, qs_d, rs_q, rs_d, dz_q, dz_d, dzo_q, dzo_d, done_q, done_d;
    logic sd, sv, fast;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0] p, t;
    assign sd = signed_div & dividend[WIDTH-1];
    assign sv = signed_div & divisor[WIDTH-1];
    assign abs_a = sd ? -dividend : dividend;
    assign abs_b = sv ? -divisor : divisor;
`ifdef DIV_ZERO_FAST_EN
    assign fast = divisor == '0;
`else
    assign fast = 1'b0;
`endif
    // Trial subtraction as add-with-carry: borrow shows up as T[WIDTH]=1
    assign p = {r_q, q_q[WIDTH-1]};
    assign t = p + ~{1'b0, d_q} + (WIDTH+1)'(1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dzo_d   = dzo_q;
        done_d  = 1'b0;
        if (cancel) begin
            state_d = IDLE;
        end else if (state_q == IDLE && start) begin
            r_d     = fast ? abs_a : '0;
            q_d     = fast ? '1 : abs_a;
            d_d     = abs_b;
            qs_d    = sd ^ sv;
            rs_d    = sd;
            dz_d    = divisor == '0;
            cnt_d   = '0;
            state_d = fast ? FIX : CALC;
        end else if (state_q == CALC) begin
            r_d     = t[WIDTH] ? p[WIDTH-1:0] : t[WIDTH-1:0];
            q_d     = {q_q[WIDTH-2:0], ~t[WIDTH]};
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(WIDTH-1)) ? FIX : CALC;
        end else if (state_q == FIX) begin
            quot_d  = qs_q ? -q_q : q_q;
            rem_d   = rs_q ? -r_q : r_q;
            dzo_d   = dz_q;
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dzo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dzo_q   <= dzo_d;
            done_q  <= done_d;
        end
    end
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dzo_q;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vector table plus cancel/reset/back-to-back sequences for div_iter.
module tb_div_iter;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, signed_div = 1'b0, cancel = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic busy, done, div_zero;
    logic [31:0] quotient, remainder;
    int n_cmp = 0, n_fail = 0;

    div_iter dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .dividend(dividend), .divisor(divisor), .cancel(cancel),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a, b, eq, er;
        logic        edz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launches at the next negedge; returns at the negedge of the done cycle.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bc);
        @(negedge clk);
        signed_div = s; dividend = a; divisor = b; start = 1'b1;
        lat = 0; bc = 0;
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
            if (done) lat = n;
        end
    endtask

    initial begin
        vec_t v [9];
        int lat, bc, lat2, ndone;
        v[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        v[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        v[2] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
        v[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
        v[4] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        v[5] = '{1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1};
        v[6] = '{1'b1, 32'hFFFFFFEC, 32'd0, 32'd1, 32'hFFFFFFEC, 1'b1};
        v[7] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0};
        v[8] = '{1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quot", quotient, 32'd0);
        chk("reset_rem", remainder, 32'd0);
        chk("reset_dz", 32'(div_zero), 32'd0);

        for (int i = 0; i < 9; i++) begin
            int elat;
`ifdef DIV_ZERO_FAST_EN
            elat = (v[i].b == 32'd0) ? 2 : 34;
`else
            elat = 34;
`endif
            do_div(v[i].s, v[i].a, v[i].b, lat, bc);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(elat));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(elat - 1));
            chk($sformatf("v%0d_quot", i), quotient, v[i].eq);
            chk($sformatf("v%0d_rem", i), remainder, v[i].er);
            chk($sformatf("v%0d_dz", i), 32'(div_zero), 32'(v[i].edz));
        end

        // Cancel at N+10: no done, prior result (0 r 5) held, then a fresh run completes
        @(negedge clk);
        signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        if (done) ndone++;
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_no_done", 32'(ndone), 32'd0);
        chk("cancel_quot_held", quotient, 32'd0);
        chk("cancel_rem_held", remainder, 32'd5);
        do_div(1'b0, 32'd100, 32'd7, lat, bc);
        chk("after_cancel_latency", 32'(lat), 32'd34);
        chk("after_cancel_quot", quotient, 32'd14);
        chk("after_cancel_rem", remainder, 32'd2);

        // Ignored start at N+5, reset at N+20
        @(negedge clk);
        signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 5) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            if (done) ndone++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done | (ndone != 0)), 32'd0);
        chk("rst_mid_quot", quotient, 32'd0);
        chk("rst_mid_rem", remainder, 32'd0);
        chk("rst_mid_dz", 32'(div_zero), 32'd0);

        // Ignored mid-run start, then back-to-back start in the done cycle
        @(negedge clk);
        signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
        lat = 0;
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 5) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            if (done) lat = n;
        end
        chk("b2b_first_latency", 32'(lat), 32'd34);
        chk("b2b_first_quot", quotient, 32'd100);
        chk("b2b_first_rem", remainder, 32'd0);
        dividend = 32'd77; divisor = 32'd8; start = 1'b1;
        lat2 = 0;
        for (int n = 1; n <= 100 && lat2 == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) lat2 = n;
        end
        chk("b2b_second_latency", 32'(lat2), 32'd34);
        chk("b2b_second_quot", quotient, 32'd9);
        chk("b2b_second_rem", remainder, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
